// File: rtl/line_fill_arbiter.sv
// Line-fill arbiter: grants read-only line-fill requesters onto a single
// downstream burst-read port in round-robin order, one burst outstanding.
module line_fill_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int RLEN_W  = 5
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_request_i,
  input  logic [NUM_REQ-1:0][29:0]        req_addr_i,
  input  logic [NUM_REQ-1:0][RLEN_W-1:0]  req_rlen_i,
  output logic [NUM_REQ-1:0]              req_ack_o,
  output logic [NUM_REQ-1:0]              req_rvalid_o,
  output logic [31:0]                     req_rdata_o,
  output logic                            mem_request_o,
  output logic [29:0]                     mem_addr_o,
  output logic [RLEN_W-1:0]               mem_rlen_o,
  input  logic                            mem_ack_i,
  input  logic                            mem_rvalid_i,
  input  logic [31:0]                     mem_rdata_i
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BURST = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [29:0]         addr_q, addr_d;
  logic [RLEN_W-1:0]   rlen_q, rlen_d;
  logic [RLEN_W-1:0]   beat_q, beat_d;

  logic                grant_valid;
  logic [IDX_W-1:0]    grant_idx;

  // Round-robin search: the first requesting index at or after rr_ptr_q wins.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    cand        = 0;
    cand_idx    = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand     = (int'(rr_ptr_q) + i) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!grant_valid && req_request_i[cand_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // Next-state and output decode; the burst owner sees downstream data only in BURST,
  // so stray beats in IDLE/ISSUE are dropped.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    addr_d        = addr_q;
    rlen_d        = rlen_q;
    beat_d        = beat_q;
    req_ack_o     = '0;
    req_rvalid_o  = '0;
    req_rdata_o   = '0;
    mem_request_o = 1'b0;
    mem_addr_o    = addr_q;
    mem_rlen_o    = rlen_q;

    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          owner_d = grant_idx;
          addr_d  = req_addr_i[grant_idx];
          rlen_d  = req_rlen_i[grant_idx];
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        mem_request_o = 1'b1;
        if (mem_ack_i) begin
          req_ack_o[owner_q] = 1'b1;
          beat_d             = rlen_q;
          if (owner_q == IDX_W'(NUM_REQ - 1)) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = owner_q + 1'b1;
          end
          state_d = BURST;
        end
      end

      BURST: begin
        req_rvalid_o[owner_q] = mem_rvalid_i;
        req_rdata_o           = mem_rdata_i;
        if (mem_rvalid_i) begin
          if (beat_q == '0) begin
            state_d = IDLE;
          end else begin
            beat_d = beat_q - 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; an asynchronous reset abandons any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      addr_q   <= '0;
      rlen_q   <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      rlen_q   <= rlen_d;
      beat_q   <= beat_d;
    end
  end

  // Protocol checks: downstream ack only against a live request, acks and
  // return-valids never to more than one requester, owner holds its request until acked.
  a_ack_needs_request : assert property (
    @(posedge clk) disable iff (!rst_n) mem_ack_i |-> mem_request_o);

  a_ack_onehot0 : assert property (
    @(posedge clk) disable iff (!rst_n) $onehot0(req_ack_o));

  a_rvalid_onehot0 : assert property (
    @(posedge clk) disable iff (!rst_n) $onehot0(req_rvalid_o));

  a_owner_holds_request : assert property (
    @(posedge clk) disable iff (!rst_n) (state_q == ISSUE) |-> req_request_i[owner_q]);

endmodule

// File: tb/tb_line_fill_arbiter.sv
// Testbench for line_fill_arbiter: requester/memory models plus a grant scoreboard.
module tb_line_fill_arbiter;

  localparam int NUM_REQ = 2;
  localparam int RLEN_W  = 5;

  typedef struct {
    int                owner;
    logic [29:0]       addr;
    logic [RLEN_W-1:0] rlen;
  } grant_t;

  logic                            clk;
  logic                            rst_n;
  logic [NUM_REQ-1:0]              req_request_i;
  logic [NUM_REQ-1:0][29:0]        req_addr_i;
  logic [NUM_REQ-1:0][RLEN_W-1:0]  req_rlen_i;
  logic [NUM_REQ-1:0]              req_ack_o;
  logic [NUM_REQ-1:0]              req_rvalid_o;
  logic [31:0]                     req_rdata_o;
  logic                            mem_request_o;
  logic [29:0]                     mem_addr_o;
  logic [RLEN_W-1:0]               mem_rlen_o;
  logic                            mem_ack_i;
  logic                            mem_rvalid_i;
  logic [31:0]                     mem_rdata_i;

  grant_t            sbQ[$];
  int                compared = 0;
  int                mismatched = 0;
  int                reqCount [NUM_REQ] = '{default: 0};
  logic [29:0]       cfgAddr [NUM_REQ] = '{default: '0};
  logic [RLEN_W-1:0] cfgRlen [NUM_REQ] = '{default: '0};
  int                rvalidSeen [NUM_REQ] = '{default: 0};
  int                ackDelay = 0;
  int                beatLatency = 0;
  bit                injectRvalid = 1'b0;
  bit                rvalidWithAck = 1'b0;
  int                memPhase = 0;
  bit                monActive = 1'b0;
  int                monOwner = 0;
  logic [29:0]       monAddr = '0;
  logic [RLEN_W-1:0] monRlen = '0;
  int                monBeat = 0;
  int                burstsDone = 0;

  line_fill_arbiter #(.NUM_REQ(NUM_REQ), .RLEN_W(RLEN_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_request_i (req_request_i),
    .req_addr_i    (req_addr_i),
    .req_rlen_i    (req_rlen_i),
    .req_ack_o     (req_ack_o),
    .req_rvalid_o  (req_rvalid_o),
    .req_rdata_o   (req_rdata_o),
    .mem_request_o (mem_request_o),
    .mem_addr_o    (mem_addr_o),
    .mem_rlen_o    (mem_rlen_o),
    .mem_ack_i     (mem_ack_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i)
  );

  // 100 MHz free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data the memory returns for a given line address and beat number
  function automatic logic [31:0] memData(input logic [29:0] addr, input int beat);
    return ({addr, 2'b00} + (32'(beat) * 32'h0101_0101)) ^ 32'hA5A5_0000;
  endfunction

  // Queue the grant a requester is expected to receive next
  task automatic pushGrant(input int owner);
    grant_t g;
    g.owner = owner;
    g.addr  = cfgAddr[owner];
    g.rlen  = cfgRlen[owner];
    sbQ.push_back(g);
  endtask

  function automatic bit benchIdle();
    bit idle;
    idle = (sbQ.size() == 0) && !monActive && (memPhase == 0);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (reqCount[i] != 0) idle = 1'b0;
    end
    return idle;
  endfunction

  // Requester and memory models, driving inputs 2 ns after each rising edge
  initial begin : driver
    int                cnt;
    int                beatNo;
    logic [29:0]       curAddr;
    logic [RLEN_W-1:0] curRlen;
    cnt = 0; beatNo = 0; curAddr = '0; curRlen = '0;
    req_request_i = '0; req_addr_i = '0; req_rlen_i = '0;
    mem_ack_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < NUM_REQ; i++) begin
        req_request_i[i] = (reqCount[i] > 0);
        req_addr_i[i]    = cfgAddr[i];
        req_rlen_i[i]    = cfgRlen[i];
      end
      mem_ack_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
      if (memPhase == 0 && mem_request_o) begin
        curAddr  = mem_addr_o;
        curRlen  = mem_rlen_o;
        beatNo   = 0;
        cnt      = ackDelay;
        memPhase = 1;
      end else if (memPhase == 0 && injectRvalid) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hBAD0_0001;
        injectRvalid = 1'b0;
      end
      if (memPhase == 1) begin
        if (cnt == 0) begin
          mem_ack_i = 1'b1;
          if (rvalidWithAck) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = 32'hBAD0_0002;
          end
          cnt      = beatLatency;
          memPhase = 2;
        end else begin
          cnt--;
        end
      end else if (memPhase == 2) begin
        if (cnt > 0) begin
          cnt--;
        end else begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = memData(curAddr, beatNo);
          beatNo++;
          if (beatNo > int'(curRlen)) memPhase = 0;
        end
      end
    end
  end

  // Scoreboard monitor on the falling edge: pops a grant on each ack, checks every beat
  initial begin : monitor
    grant_t exp;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        monActive = 1'b0;
        continue;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_rvalid_o[i]) rvalidSeen[i]++;
      end
      if (req_rvalid_o != '0) begin
        compared++;
        if (!monActive) begin
          mismatched++;
          $display("[TB] FAIL rvalid_unexpected: req_rvalid=%b data=%h, required no rvalid", req_rvalid_o, req_rdata_o);
        end else begin
          if (req_rvalid_o !== NUM_REQ'(1 << monOwner) || req_rdata_o !== memData(monAddr, monBeat)) begin
            mismatched++;
            $display("[TB] FAIL beat%0d: req_rvalid=%b data=%h, required req_rvalid=%b data=%h",
                     monBeat, req_rvalid_o, req_rdata_o, NUM_REQ'(1 << monOwner), memData(monAddr, monBeat));
          end
          monBeat++;
          if (monBeat > int'(monRlen)) begin
            monActive = 1'b0;
            burstsDone++;
          end
        end
      end
      if (req_ack_o != '0) begin
        compared++;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (req_ack_o[i] && reqCount[i] > 0) reqCount[i]--;
        end
        if (sbQ.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL ack_unexpected: req_ack=%b, required no ack", req_ack_o);
        end else begin
          exp = sbQ.pop_front();
          if (req_ack_o !== NUM_REQ'(1 << exp.owner) || mem_addr_o !== exp.addr ||
              mem_rlen_o !== exp.rlen || mem_ack_i !== 1'b1 || mem_request_o !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL grant: ack=%b addr=%h rlen=%0d mem_req=%b mem_ack=%b, required ack=%b addr=%h rlen=%0d mem_req=1 mem_ack=1",
                     req_ack_o, mem_addr_o, mem_rlen_o, mem_request_o, mem_ack_i,
                     NUM_REQ'(1 << exp.owner), exp.addr, exp.rlen);
          end
          monActive = 1'b1;
          monOwner  = exp.owner;
          monAddr   = exp.addr;
          monRlen   = exp.rlen;
          monBeat   = 0;
        end
      end
    end
  end

  // Waits until every queued grant and burst has completed
  task automatic waitDrain(input string name, input int budget);
    int n;
    n = 0;
    while (n < budget && !benchIdle()) begin
      @(negedge clk);
      #1;
      n++;
    end
    compared++;
    if (n >= budget) begin
      mismatched++;
      $display("[TB] FAIL %s: still busy after %0d cycles, required drained (queue=%0d)", name, budget, sbQ.size());
      sbQ.delete();
      for (int i = 0; i < NUM_REQ; i++) reqCount[i] = 0;
    end
  endtask

  // Waits until the given number of bursts has completed
  task automatic waitBursts(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (n < budget && burstsDone < target) begin
      @(negedge clk);
      #1;
      n++;
    end
    compared++;
    if (burstsDone < target) begin
      mismatched++;
      $display("[TB] FAIL %s: bursts done %0d, required %0d", name, burstsDone, target);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    compared++;
    if (req_ack_o !== '0) begin mismatched++; $display("[TB] FAIL reset_req_ack: got %b, required 0", req_ack_o); end
    compared++;
    if (req_rvalid_o !== '0) begin mismatched++; $display("[TB] FAIL reset_req_rvalid: got %b, required 0", req_rvalid_o); end
    compared++;
    if (req_rdata_o !== '0) begin mismatched++; $display("[TB] FAIL reset_req_rdata: got %h, required 0", req_rdata_o); end
    compared++;
    if (mem_request_o !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_mem_request: got %b, required 0", mem_request_o); end
    compared++;
    if (mem_addr_o !== '0) begin mismatched++; $display("[TB] FAIL reset_mem_addr: got %h, required 0", mem_addr_o); end
    compared++;
    if (mem_rlen_o !== '0) begin mismatched++; $display("[TB] FAIL reset_mem_rlen: got %0d, required 0", mem_rlen_o); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      compared++;
      if (mem_request_o !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_no_request: mem_request=%b, required 0", mem_request_o); end
    end
  endtask

  task automatic test_contention();
    int seen0, seen1;
    rst_n = 1'b0;
    ackDelay = 1; beatLatency = 1;
    cfgAddr[0] = 30'h0000_0400; cfgRlen[0] = RLEN_W'(3);
    cfgAddr[1] = 30'h0000_0800; cfgRlen[1] = RLEN_W'(2);
    seen0 = rvalidSeen[0]; seen1 = rvalidSeen[1];
    pushGrant(0); pushGrant(1); pushGrant(0);
    reqCount[0] = 2; reqCount[1] = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    waitDrain("contention_drain", 300);
    compared++;
    if (rvalidSeen[0] - seen0 !== 8) begin mismatched++; $display("[TB] FAIL contention_beats0: got %0d, required 8", rvalidSeen[0] - seen0); end
    compared++;
    if (rvalidSeen[1] - seen1 !== 3) begin mismatched++; $display("[TB] FAIL contention_beats1: got %0d, required 3", rvalidSeen[1] - seen1); end
  endtask

  task automatic test_single();
    int n, issueCycles, seen0, seen1;
    ackDelay = 3; beatLatency = 0;
    cfgAddr[0] = 30'h0000_0100; cfgRlen[0] = RLEN_W'(7);
    seen0 = rvalidSeen[0]; seen1 = rvalidSeen[1];
    pushGrant(0);
    reqCount[0] = 1;
    n = 0; issueCycles = 0;
    while (n < 50) begin
      @(negedge clk);
      #1;
      n++;
      if (mem_request_o) begin
        issueCycles++;
        compared++;
        if (mem_addr_o !== 30'h0000_0100 || mem_rlen_o !== RLEN_W'(7)) begin
          mismatched++;
          $display("[TB] FAIL single_issue_hold: addr=%h rlen=%0d, required addr=100 rlen=7", mem_addr_o, mem_rlen_o);
        end
      end
      if (req_ack_o != '0) break;
    end
    compared++;
    if (issueCycles !== 4) begin mismatched++; $display("[TB] FAIL single_issue_cycles: got %0d, required 4", issueCycles); end
    @(negedge clk);
    #1;
    compared++;
    if (mem_request_o !== 1'b0) begin mismatched++; $display("[TB] FAIL single_request_drop: mem_request=%b, required 0", mem_request_o); end
    waitDrain("single_drain", 100);
    compared++;
    if (rvalidSeen[0] - seen0 !== 8) begin mismatched++; $display("[TB] FAIL single_beats0: got %0d, required 8", rvalidSeen[0] - seen0); end
    compared++;
    if (rvalidSeen[1] - seen1 !== 0) begin mismatched++; $display("[TB] FAIL single_beats1: got %0d, required 0", rvalidSeen[1] - seen1); end
  endtask

  task automatic test_single_beat();
    int seen0, seen1;
    ackDelay = 1; beatLatency = 0; rvalidWithAck = 1'b1;
    cfgAddr[1] = 30'h0000_02A0; cfgRlen[1] = RLEN_W'(0);
    seen0 = rvalidSeen[0]; seen1 = rvalidSeen[1];
    pushGrant(1);
    reqCount[1] = 1;
    waitBursts("single_beat_done", burstsDone + 1, 50);
    rvalidWithAck = 1'b0;
    injectRvalid  = 1'b1;
    @(negedge clk);
    #1;
    compared++;
    if (req_rvalid_o !== '0) begin mismatched++; $display("[TB] FAIL single_beat_after: req_rvalid=%b, required 0", req_rvalid_o); end
    waitDrain("single_beat_drain", 50);
    compared++;
    if (rvalidSeen[1] - seen1 !== 1) begin mismatched++; $display("[TB] FAIL single_beat_count1: got %0d, required 1", rvalidSeen[1] - seen1); end
    compared++;
    if (rvalidSeen[0] - seen0 !== 0) begin mismatched++; $display("[TB] FAIL single_beat_count0: got %0d, required 0", rvalidSeen[0] - seen0); end
  endtask

  task automatic test_back_to_back();
    int n;
    ackDelay = 0; beatLatency = 0;
    cfgAddr[0] = 30'h0000_0300; cfgRlen[0] = RLEN_W'(3);
    cfgAddr[1] = 30'h0000_0340; cfgRlen[1] = RLEN_W'(1);
    // Same requester asks again while its burst is still running
    pushGrant(0); pushGrant(0);
    reqCount[0] = 2;
    waitBursts("b2b_self_first", burstsDone + 1, 60);
    @(negedge clk);
    #1;
    compared++;
    if (mem_request_o !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_self_gap: mem_request=%b, required 0", mem_request_o); end
    @(negedge clk);
    #1;
    compared++;
    if (mem_request_o !== 1'b1 || mem_addr_o !== 30'h0000_0300) begin
      mismatched++;
      $display("[TB] FAIL b2b_self_issue: mem_request=%b addr=%h, required 1 / 300", mem_request_o, mem_addr_o);
    end
    waitDrain("b2b_self_drain", 60);
    // Other requester arrives mid-burst and must win the slot after the gap
    pushGrant(0);
    reqCount[0] = 2;
    n = 0;
    while (n < 60 && sbQ.size() != 0) begin
      @(negedge clk);
      #1;
      n++;
    end
    compared++;
    if (sbQ.size() != 0) begin mismatched++; $display("[TB] FAIL b2b_other_ack: no ack after %0d cycles, required ack", n); end
    pushGrant(1); pushGrant(0);
    reqCount[1] = 1;
    waitBursts("b2b_other_first", burstsDone + 1, 60);
    @(negedge clk);
    #1;
    compared++;
    if (mem_request_o !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_other_gap: mem_request=%b, required 0", mem_request_o); end
    @(negedge clk);
    #1;
    compared++;
    if (mem_request_o !== 1'b1 || mem_addr_o !== 30'h0000_0340) begin
      mismatched++;
      $display("[TB] FAIL b2b_other_issue: mem_request=%b addr=%h, required 1 / 340", mem_request_o, mem_addr_o);
    end
    waitDrain("b2b_other_drain", 100);
  endtask

  task automatic test_spurious();
    injectRvalid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      compared++;
      if (req_rvalid_o !== '0) begin mismatched++; $display("[TB] FAIL spurious_idle: req_rvalid=%b, required 0", req_rvalid_o); end
    end
  endtask

  task automatic test_reset_mid_burst();
    int n, seen0, seen1;
    ackDelay = 1; beatLatency = 0;
    cfgAddr[0] = 30'h0000_0500; cfgRlen[0] = RLEN_W'(7);
    pushGrant(0);
    reqCount[0] = 1;
    n = 0;
    while (n < 60 && !(monActive && monBeat == 3)) begin
      @(negedge clk);
      #1;
      n++;
    end
    compared++;
    if (!(monActive && monBeat == 3)) begin mismatched++; $display("[TB] FAIL midrst_progress: beats %0d, required 3", monBeat); end
    rst_n = 1'b0;
    #1;
    compared++;
    if (req_rvalid_o !== '0) begin mismatched++; $display("[TB] FAIL midrst_rvalid: got %b, required 0", req_rvalid_o); end
    compared++;
    if (req_rdata_o !== '0) begin mismatched++; $display("[TB] FAIL midrst_rdata: got %h, required 0", req_rdata_o); end
    compared++;
    if (req_ack_o !== '0 || mem_request_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL midrst_req: ack=%b mem_request=%b, required 0 / 0", req_ack_o, mem_request_o);
    end
    compared++;
    if (mem_addr_o !== '0 || mem_rlen_o !== '0) begin
      mismatched++;
      $display("[TB] FAIL midrst_mem: addr=%h rlen=%0d, required 0 / 0", mem_addr_o, mem_rlen_o);
    end
    seen0 = rvalidSeen[0]; seen1 = rvalidSeen[1];
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    waitDrain("midrst_tail", 40);
    compared++;
    if (rvalidSeen[0] - seen0 !== 0 || rvalidSeen[1] - seen1 !== 0) begin
      mismatched++;
      $display("[TB] FAIL midrst_dropped: forwarded %0d/%0d beats, required 0/0", rvalidSeen[0] - seen0, rvalidSeen[1] - seen1);
    end
    // Pointer is back at 0, so requester 0 wins even though it was served last
    cfgAddr[1] = 30'h0000_0540; cfgRlen[1] = RLEN_W'(2);
    pushGrant(0); pushGrant(1);
    reqCount[0] = 1; reqCount[1] = 1;
    waitDrain("midrst_regrant", 150);
  endtask

  // Watchdog against a hung run
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Test sequence
  initial begin
    rst_n = 1'b0;
    test_reset();
    test_contention();
    test_single();
    test_single_beat();
    test_back_to_back();
    test_spurious();
    test_reset_mid_burst();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/line_fill_arbiter.md
LINE_FILL_ARBITER -- requirements
Module: line_fill_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2: number of read-only line-fill requesters (range 2-4).
REQ-002 Parameter RLEN_W, default 5: burst-length field width; burst = rlen+1 words.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_request  input  NUM_REQ  per-requester line-fill request, held high until acked.
REQ-006 req_addr  input  NUM_REQ x 30  per-requester word address (byte address [31:2]).
REQ-007 req_rlen  input  NUM_REQ x RLEN_W  per-requester burst length minus one.
REQ-008 req_ack  output  NUM_REQ  one-cycle acceptance pulse to the owning requester.
REQ-009 req_rvalid  output  NUM_REQ  per-requester return-data valid.
REQ-010 req_rdata  output  32  return data, shared by all requesters, qualified by req_rvalid.
REQ-011 mem_request  output  1  downstream read request.
REQ-012 mem_addr  output  30  downstream word address.
REQ-013 mem_rlen  output  RLEN_W  downstream burst length minus one.
REQ-014 mem_ack  input  1  downstream acceptance, valid only while mem_request is high.
REQ-015 mem_rvalid  input  1  downstream return-data valid.
REQ-016 mem_rdata  input  32  downstream return data.

Function
REQ-017 FSM states: IDLE, ISSUE, BURST; one burst outstanding at a time.
REQ-018 IDLE: any req_request high -> round-robin grant (lowest index at/after rr_ptr wins), owner, addr and rlen registered, next state ISSUE.
REQ-019 IDLE with no request: remain IDLE; mem_request low.
REQ-020 ISSUE: mem_request=1, mem_addr/mem_rlen from registered values (stable until mem_ack).
REQ-021 ISSUE with mem_ack: req_ack[owner]=1 same cycle (combinational); beat counter loaded with registered rlen; rr_ptr <= owner+1 modulo NUM_REQ; next state BURST.
REQ-022 mem_request deasserts the cycle after mem_ack.
REQ-023 BURST: req_rvalid[owner]=mem_rvalid; req_rdata=mem_rdata; all other req_rvalid bits 0.
REQ-024 BURST: each mem_rvalid decrements beat counter; mem_rvalid with counter==0 -> IDLE.
REQ-025 rlen=0: single-beat burst; first mem_rvalid returns to IDLE.
REQ-026 Maximum burst 2^RLEN_W words; counter never wraps below zero.
REQ-027 Final-beat cycle: no new grant; new grant evaluated in following IDLE cycle (one-cycle gap).
REQ-028 mem_rvalid in IDLE or ISSUE: dropped, no req_rvalid asserted.
REQ-029 Requester deasserting req_request before its ack: grant remains; burst completes to that requester (protocol violation, flagged by assertion).
REQ-030 Requests arriving during ISSUE/BURST: held by requester, not lost; serviced round-robin afterward.
REQ-031 mem_ack, mem_rvalid same cycle in ISSUE: ack honoured; rvalid dropped (downstream latency >=1 required).

Reset
REQ-032 rst_n low, asynchronously: state=IDLE, rr_ptr=0, beat counter=0, owner=0.
REQ-033 Reset outputs: req_ack=0, req_rvalid=0, mem_request=0, mem_addr=0, mem_rlen=0, req_rdata=0.
REQ-034 Reset mid-burst: burst abandoned; no data forwarded after reset release until a new grant.
REQ-035 Assertions (disabled in reset): mem_ack implies mem_request; at most one req_ack bit high; req_rvalid one-hot or zero.

Verification
REQ-036 Single requester: req0 addr=0x100, rlen=7, mem_ack after 3 cycles, 8 rvalid beats -> req_ack[0] one pulse, 8 req_rvalid[0] pulses with matching data, return to IDLE.
REQ-037 Contention: req0 and req1 both high from reset -> req0 served first, then req1, then req0 again if still requesting (round-robin).
REQ-038 Single-beat: req1 rlen=0 -> one req_rvalid[1], IDLE next cycle, req_rvalid[0] never asserted.
REQ-039 Back-to-back: req0 re-requests on final beat -> IDLE gap of exactly one cycle, then ISSUE for req1 if pending else req0.
REQ-040 Spurious data: mem_rvalid pulsed in IDLE -> no req_rvalid bit asserted.
REQ-041 Reset mid-burst after 3 of 8 beats -> all outputs 0 immediately; remaining mem_rvalid beats dropped; next request granted normally.
